brom_map: RTL and testbench
===========================

Name: brom_map

Overview:
- Address-decode and overlay stage directly upstream of the 256-byte boot ROM.
- Sits between the CPU bus and the boot ROM / external (cartridge) bus.
- While boot mode is active, CPU reads in 0x0000–0x00FF are steered to the boot ROM; all other traffic goes to the external bus.
- A one-shot, sticky write to the lock register (0xFF50) permanently unmaps the boot ROM until reset.
- Read data is registered, with one-cycle latency and a valid strobe.

Parameters:
- LOCK_ADDR, 16'hFF50, address of the boot-ROM disable register.
- BROM_TOP, 16'h00FF, highest CPU address overlaid by the boot ROM while mapped; the window always starts at 0x0000.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  16  CPU address.
- din  in  8  CPU write data.
- rd  in  1  CPU read strobe, one cycle per access.
- wr  in  1  CPU write strobe, one cycle per access.
- dout  out  8  registered read data to the CPU.
- rd_valid  out  1  high for the one cycle in which dout holds the data for the previous rd.
- brom_a  out  8  boot ROM address; combinational, equal to a[7:0].
- brom_d  in  8  boot ROM data; combinational, valid in the same cycle as brom_a.
- ext_a  out  16  external bus address; equal to a.
- ext_dout  out  8  external write data; equal to din.
- ext_din  in  8  external read data; combinational, valid in the same cycle.
- ext_rd  out  1  external read strobe.
- ext_wr  out  1  external write strobe.
- boot_en  out  1  high while the boot ROM is mapped.
- boot_done  out  1  single-cycle pulse in the cycle after boot_en falls.

Behaviour:
- Reset values: boot_en=1, dout=8'h00, rd_valid=0, boot_done=0.
- brom_hit (internal, combinational) = boot_en && (a <= BROM_TOP).
- lock_hit (internal, combinational) = (a == LOCK_ADDR).
- Read cycle (rd=1):
  - brom_hit: ext_rd=0; dout <= brom_d at the next edge.
  - lock_hit: ext_rd=0; dout <= 8'hFF.
  - otherwise: ext_rd=1; dout <= ext_din.
  - In all three cases rd_valid=1 in the following cycle.
- rd=0: rd_valid=0 next cycle; dout holds its last value.
- Write cycle (wr=1):
  - lock_hit: ext_wr=0; if din != 0 and boot_en=1, boot_en <= 0 at the edge. A write of 0 has no effect.
  - Any other address, including 0x0000–0x00FF while mapped: ext_wr=1 (MBC registers live there); the boot ROM is never written.
- boot_en is sticky. Once 0, only rst sets it back to 1; further lock writes of any value are ignored and still not forwarded.
- boot_done=1 exactly in the cycle after the cycle in which boot_en transitioned 1->0; otherwise 0.
- Access immediately after the unlocking write: a read of 0x0000 in the next cycle sees boot_en=0 and goes external.
- rd and wr both high in one cycle: illegal on the CPU bus. The block must behave as if only wr were asserted: no ext_rd, rd_valid=0 next cycle.
- Decode and strobe outputs are purely combinational from a/rd/wr/boot_en. Only dout, rd_valid, boot_en and boot_done are registers.
- rst asserted mid-operation: at that edge all registers take their reset values regardless of rd/wr. A pending read produces no rd_valid.
- Address compare is full 16-bit unsigned; no wrap-around or aliasing of the window or lock address.

Test Plan:
- Reset, then rd at a=0x0000 with brom_d=8'h31, ext_din=8'hAA -> ext_rd=0 that cycle; next cycle dout=8'h31, rd_valid=1.
- rd at a=0x0100 with ext_din=8'hCE while boot_en=1 -> ext_rd=1; next cycle dout=8'hCE.
- wr a=0xFF50 din=8'h00 -> boot_en stays 1, ext_wr=0. Then wr din=8'h01 -> boot_en=0 after the edge, boot_done pulses once, ext_wr=0. Then rd a=0x0000 with ext_din=8'h3C -> dout=8'h3C.
- After unlock: wr a=0xFF50 din=8'h01 again -> no boot_done, boot_en stays 0. rd a=0xFF50 -> dout=8'hFF.
- wr a=0x0050 din=8'h0A while mapped -> ext_wr=1, ext_a=16'h0050, ext_dout=8'h0A.
- Unlock, then rst for one cycle -> boot_en=1, dout=0, rd_valid=0. A rd issued in the same cycle as rst gives rd_valid=0 afterwards; rd a=0x0000 then returns brom_d.

Source files
------------

// File: rtl/brom_map.sv
//------------------------------------------------------------------------------
// brom_map : boot-ROM overlay and address decode between the CPU bus and the
//            256-byte boot ROM / external cartridge bus, with sticky unlock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module brom_map #(
    parameter logic [15:0] LOCK_ADDR = 16'hFF50,
    parameter logic [15:0] BROM_TOP  = 16'h00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  dout,
    output logic        rd_valid,
    output logic [7:0]  brom_a,
    input  logic [7:0]  brom_d,
    output logic [15:0] ext_a,
    output logic [7:0]  ext_dout,
    input  logic [7:0]  ext_din,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic        boot_en,
    output logic        boot_done
);

    localparam logic [7:0] c_LOCK_RDATA = 8'hFF;

    logic       r_boot_en;
    logic       r_boot_done;
    logic       r_rd_valid;
    logic [7:0] r_dout;

    logic       w_brom_hit;
    logic       w_lock_hit;
    logic       w_rd_eff;
    logic       w_unlock;
    logic [7:0] w_rdata;

    assign w_brom_hit = r_boot_en && (a <= BROM_TOP);
    assign w_lock_hit = (a == LOCK_ADDR);

    // A simultaneous rd+wr is treated as a pure write.
    assign w_rd_eff   = rd && !wr;
    assign w_unlock   = wr && w_lock_hit && (din != 8'h00) && r_boot_en;

    assign brom_a   = a[7:0];
    assign ext_a    = a;
    assign ext_dout = din;
    assign ext_rd   = w_rd_eff && !w_brom_hit && !w_lock_hit;
    assign ext_wr   = wr && !w_lock_hit;

    always_comb begin
        w_rdata = ext_din;
        if (w_brom_hit) begin
            w_rdata = brom_d;
        end else if (w_lock_hit) begin
            w_rdata = c_LOCK_RDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_boot_en   <= 1'b1;
            r_boot_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_dout      <= 8'h00;
        end else begin
            r_rd_valid  <= w_rd_eff;
            r_boot_done <= w_unlock;
            if (w_rd_eff) begin
                r_dout <= w_rdata;
            end
            // Sticky: only reset can re-map the boot ROM.
            if (w_unlock) begin
                r_boot_en <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign rd_valid  = r_rd_valid;
    assign boot_en   = r_boot_en;
    assign boot_done = r_boot_done;

endmodule

`default_nettype wire

// File: tb/tb_brom_map.sv
//------------------------------------------------------------------------------
// tb_brom_map : directed self-checking bench for brom_map.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_brom_map;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  din;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic        rd_valid;
    logic [7:0]  brom_a;
    logic [7:0]  brom_d;
    logic [15:0] ext_a;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        ext_rd;
    logic        ext_wr;
    logic        boot_en;
    logic        boot_done;

    int total = 0;
    int bad   = 0;

    brom_map dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .din       (din),
        .rd        (rd),
        .wr        (wr),
        .dout      (dout),
        .rd_valid  (rd_valid),
        .brom_a    (brom_a),
        .brom_d    (brom_d),
        .ext_a     (ext_a),
        .ext_dout  (ext_dout),
        .ext_din   (ext_din),
        .ext_rd    (ext_rd),
        .ext_wr    (ext_wr),
        .boot_en   (boot_en),
        .boot_done (boot_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        total++; if (boot_en !== 1'b1)   begin bad++; $display("FAIL reset_boot_en got=%b exp=1", boot_en); end
        total++; if (dout !== 8'h00)     begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL reset_boot_done got=%b exp=0", boot_done); end
    endtask

    task automatic test_brom_read;
        a = 16'h0000; rd = 1'b1; brom_d = 8'h31; ext_din = 8'hAA;
        #1;
        total++; if (ext_rd !== 1'b0)  begin bad++; $display("FAIL brom_ext_rd got=%b exp=0", ext_rd); end
        total++; if (brom_a !== 8'h00) begin bad++; $display("FAIL brom_a got=%h exp=00", brom_a); end
        tick();
        total++; if (dout !== 8'h31)    begin bad++; $display("FAIL brom_dout got=%h exp=31", dout); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL brom_rd_valid got=%b exp=1", rd_valid); end
        // top of window still overlaid
        a = 16'h00FF; brom_d = 8'h5A; ext_din = 8'h11;
        #1;
        total++; if (ext_rd !== 1'b0)  begin bad++; $display("FAIL brom_top_ext_rd got=%b exp=0", ext_rd); end
        total++; if (brom_a !== 8'hFF) begin bad++; $display("FAIL brom_top_a got=%h exp=ff", brom_a); end
        tick();
        total++; if (dout !== 8'h5A) begin bad++; $display("FAIL brom_top_dout got=%h exp=5a", dout); end
        idle();
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
        total++; if (dout !== 8'h5A)    begin bad++; $display("FAIL idle_dout_hold got=%h exp=5a", dout); end
    endtask

    task automatic test_ext_read;
        a = 16'h0100; rd = 1'b1; ext_din = 8'hCE; brom_d = 8'h99;
        #1;
        total++; if (ext_rd !== 1'b1)    begin bad++; $display("FAIL ext_rd got=%b exp=1", ext_rd); end
        total++; if (ext_a !== 16'h0100) begin bad++; $display("FAIL ext_a got=%h exp=0100", ext_a); end
        tick();
        total++; if (dout !== 8'hCE)     begin bad++; $display("FAIL ext_dout_rd got=%h exp=ce", dout); end
        total++; if (rd_valid !== 1'b1)  begin bad++; $display("FAIL ext_rd_valid got=%b exp=1", rd_valid); end
        idle();
        tick();
    endtask

    task automatic test_write_mapped;
        a = 16'h0050; din = 8'h0A; wr = 1'b1;
        #1;
        total++; if (ext_wr !== 1'b1)     begin bad++; $display("FAIL mbc_ext_wr got=%b exp=1", ext_wr); end
        total++; if (ext_a !== 16'h0050)  begin bad++; $display("FAIL mbc_ext_a got=%h exp=0050", ext_a); end
        total++; if (ext_dout !== 8'h0A)  begin bad++; $display("FAIL mbc_ext_dout got=%h exp=0a", ext_dout); end
        total++; if (ext_rd !== 1'b0)     begin bad++; $display("FAIL mbc_ext_rd got=%b exp=0", ext_rd); end
        tick();
        total++; if (boot_en !== 1'b1)    begin bad++; $display("FAIL mbc_boot_en got=%b exp=1", boot_en); end
        total++; if (rd_valid !== 1'b0)   begin bad++; $display("FAIL mbc_rd_valid got=%b exp=0", rd_valid); end
        idle();
    endtask

    task automatic test_rd_wr_both;
        a = 16'h0100; din = 8'h22; rd = 1'b1; wr = 1'b1; ext_din = 8'h77;
        #1;
        total++; if (ext_rd !== 1'b0) begin bad++; $display("FAIL both_ext_rd got=%b exp=0", ext_rd); end
        total++; if (ext_wr !== 1'b1) begin bad++; $display("FAIL both_ext_wr got=%b exp=1", ext_wr); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL both_rd_valid got=%b exp=0", rd_valid); end
        total++; if (dout !== 8'hCE)    begin bad++; $display("FAIL both_dout_hold got=%h exp=ce", dout); end
        idle();
    endtask

    task automatic test_unlock;
        a = 16'hFF50; din = 8'h00; wr = 1'b1;
        #1;
        total++; if (ext_wr !== 1'b0) begin bad++; $display("FAIL lock0_ext_wr got=%b exp=0", ext_wr); end
        tick();
        total++; if (boot_en !== 1'b1)   begin bad++; $display("FAIL lock0_boot_en got=%b exp=1", boot_en); end
        total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL lock0_boot_done got=%b exp=0", boot_done); end
        din = 8'h01;
        #1;
        total++; if (ext_wr !== 1'b0) begin bad++; $display("FAIL lock1_ext_wr got=%b exp=0", ext_wr); end
        tick();
        total++; if (boot_en !== 1'b0)   begin bad++; $display("FAIL lock1_boot_en got=%b exp=0", boot_en); end
        total++; if (boot_done !== 1'b1) begin bad++; $display("FAIL lock1_boot_done got=%b exp=1", boot_done); end
        // read of 0x0000 right after unlocking goes external
        wr = 1'b0; rd = 1'b1; a = 16'h0000; ext_din = 8'h3C; brom_d = 8'h31;
        #1;
        total++; if (ext_rd !== 1'b1) begin bad++; $display("FAIL post_unlock_ext_rd got=%b exp=1", ext_rd); end
        tick();
        total++; if (dout !== 8'h3C)     begin bad++; $display("FAIL post_unlock_dout got=%h exp=3c", dout); end
        total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL boot_done_pulse_end got=%b exp=0", boot_done); end
        idle();
    endtask

    task automatic test_after_unlock;
        a = 16'hFF50; din = 8'h01; wr = 1'b1;
        #1;
        total++; if (ext_wr !== 1'b0) begin bad++; $display("FAIL relock_ext_wr got=%b exp=0", ext_wr); end
        tick();
        total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL relock_boot_done got=%b exp=0", boot_done); end
        total++; if (boot_en !== 1'b0)   begin bad++; $display("FAIL relock_boot_en got=%b exp=0", boot_en); end
        wr = 1'b0; rd = 1'b1; ext_din = 8'h55;
        #1;
        total++; if (ext_rd !== 1'b0) begin bad++; $display("FAIL lock_rd_ext_rd got=%b exp=0", ext_rd); end
        tick();
        total++; if (dout !== 8'hFF) begin bad++; $display("FAIL lock_rd_dout got=%h exp=ff", dout); end
        // neighbour of the lock address is ordinary external space
        a = 16'hFF51; ext_din = 8'h12;
        #1;
        total++; if (ext_rd !== 1'b1) begin bad++; $display("FAIL ff51_ext_rd got=%b exp=1", ext_rd); end
        tick();
        total++; if (dout !== 8'h12) begin bad++; $display("FAIL ff51_dout got=%h exp=12", dout); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; rd = 1'b1; a = 16'h0100; ext_din = 8'hE7;
        tick();
        rst = 1'b0;
        total++; if (boot_en !== 1'b1)  begin bad++; $display("FAIL mid_rst_boot_en got=%b exp=1", boot_en); end
        total++; if (dout !== 8'h00)    begin bad++; $display("FAIL mid_rst_dout got=%h exp=00", dout); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_valid got=%b exp=0", rd_valid); end
        a = 16'h0000; brom_d = 8'h77; ext_din = 8'h88;
        tick();
        total++; if (dout !== 8'h77)    begin bad++; $display("FAIL remap_dout got=%h exp=77", dout); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL remap_rd_valid got=%b exp=1", rd_valid); end
        idle();
    endtask

    initial begin
        rst = 1'b1; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
        brom_d = 8'h00; ext_din = 8'h00;
        test_reset();
        test_brom_read();
        test_ext_read();
        test_write_mapped();
        test_rd_wr_both();
        test_unlock();
        test_after_unlock();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
